// File: rtl/frame_capture_buffer_pkg.sv
// Shared definitions for the frame capture buffer.
//   cap_state_e    : capture controller states
//   CRC_POLY/INIT  : CRC-16-CCITT constants used by the optional frame CRC
//   MAX_X/MAX_Y    : largest drawable area a capture window may cover
//   decim_legal()  : elaboration-time legality check for the decimation factor
//   crc16_word()   : MSB-first bit-serial CRC-16 update over an nbits-wide word
package frame_capture_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_e;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    localparam int unsigned MAX_X = 32'd640;
    localparam int unsigned MAX_Y = 32'd480;

    function automatic bit decim_legal(input int unsigned d);
        return (d == 32'd1) || (d == 32'd2) || (d == 32'd4);
    endfunction

    // The word is left-aligned first so bits can be consumed from the top
    // without a variable bit index.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                               input logic [31:0] data,
                                               input int unsigned nbits);
        logic [15:0] crc_v;
        logic [31:0] sh_v;
        logic        fb_v;
        crc_v = crc_in;
        sh_v  = data << (32'd32 - nbits);
        for (int unsigned k = 0; k < nbits; k++) begin
            fb_v  = crc_v[15] ^ sh_v[31];
            crc_v = {crc_v[14:0], 1'b0} ^ (fb_v ? CRC_POLY : 16'h0000);
            sh_v  = {sh_v[30:0], 1'b0};
        end
        return crc_v;
    endfunction

endpackage

// File: rtl/frame_capture_buffer_capture_ram.sv
// capture_ram: simple dual-port synchronous RAM, DEPTH x DW.
//   clk, reset           : clock, asynchronous active-high reset (read register only)
//   wr_en/wr_addr/wr_data: write port
//   rd_en/rd_addr        : read port, one clock latency
//   rd_data              : registered read data; a read of the address being
//                          written in the same clock returns the old word
module capture_ram #(
    parameter int unsigned DEPTH = 32'd4800,
    parameter int unsigned DW    = 32'd12,
    parameter int unsigned AW    = 32'd13
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] rd_data_d;

    // Storage array write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read data selection: load a new word on rd_en, otherwise hold.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Read output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_capture_buffer.sv
// frame_capture_buffer: captures a (decimated) window of one video frame into
// an on-chip RAM that can be read back at any time.
//   clk, reset        : system clock, asynchronous active-high reset
//   pix_ce, vs, vde   : pixel strobe, vertical sync (active low), active video
//   drawX, drawY      : current pixel coordinates
//   Red, Green, Blue  : pixel colour, COLOR_W bits each
//   arm, abort        : start capture of the next full frame / cancel
//   busy, done        : capture in progress / capture finished (sticky to next arm)
//   frame_cnt         : vs falling edges seen since reset
//   rd_en, rd_addr    : read request; rd_data ({B,G,R}) and rd_valid one clock later
//   crc               : only with FRAME_CAPTURE_CRC_EN defined; CRC-16-CCITT over
//                       the written words of the current capture
module frame_capture_buffer
    import frame_capture_buffer_pkg::*;
#(
    parameter int unsigned COLOR_W = 32'd4,
    parameter int unsigned WIN_X0  = 32'd0,
    parameter int unsigned WIN_Y0  = 32'd0,
    parameter int unsigned WIN_W   = 32'd80,
    parameter int unsigned WIN_H   = 32'd60,
    parameter int unsigned DECIM   = 32'd1,
    localparam int unsigned DEPTH  = WIN_W * WIN_H,
    localparam int unsigned AW     = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_ce,
    input  logic                 vs,
    input  logic                 vde,
    input  logic [9:0]           drawX,
    input  logic [9:0]           drawY,
    input  logic [COLOR_W-1:0]   Red,
    input  logic [COLOR_W-1:0]   Green,
    input  logic [COLOR_W-1:0]   Blue,
    input  logic                 arm,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          frame_cnt,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic [3*COLOR_W-1:0] rd_data,
`ifdef FRAME_CAPTURE_CRC_EN
    output logic [15:0]          crc,
`endif
    output logic                 rd_valid
);

    localparam int unsigned CW  = 3 * COLOR_W;
    localparam int unsigned DSH = (DECIM == 32'd4) ? 32'd2 : ((DECIM == 32'd2) ? 32'd1 : 32'd0);

    if (!decim_legal(DECIM) || (WIN_X0 + WIN_W * DECIM > MAX_X) ||
        (WIN_Y0 + WIN_H * DECIM > MAX_Y)) begin : g_bad_cfg
        $error("frame_capture_buffer: illegal DECIM or capture window outside 640x480");
    end

    cap_state_e    state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          vs_q, vs_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          rd_valid_q, rd_valid_d;
    logic [11:0]   dx_s, dy_s;
    logic [10:0]   col_s, row_s;
    logic          hit_s, wr_en_s, wr_last_s, vs_fall_s;
    logic [AW-1:0] wr_addr_s;
    logic [CW-1:0] wr_data_s;

    // Window hit, decimation grid and write address. A borrow in the 12-bit
    // difference means the pixel lies left of / above the window.
    always_comb begin
        dx_s      = {2'b00, drawX} - 12'(WIN_X0);
        dy_s      = {2'b00, drawY} - 12'(WIN_Y0);
        col_s     = dx_s[10:0] >> DSH;
        row_s     = dy_s[10:0] >> DSH;
        hit_s     = !dx_s[11] && (dx_s[10:0] < 11'(WIN_W * DECIM)) &&
                    !dy_s[11] && (dy_s[10:0] < 11'(WIN_H * DECIM)) &&
                    ((dx_s[10:0] & 11'(DECIM - 32'd1)) == 11'd0) &&
                    ((dy_s[10:0] & 11'(DECIM - 32'd1)) == 11'd0);
        wr_addr_s = AW'(row_s) * AW'(WIN_W) + AW'(col_s);
        wr_data_s = {Blue, Green, Red};
        vs_fall_s = pix_ce && vs_q && !vs;
        wr_en_s   = (state_q == ST_CAPTURE) && pix_ce && vde && hit_s;
        wr_last_s = wr_en_s && (wr_addr_s == AW'(DEPTH - 32'd1));
    end

    // Controller next state; abort overrides everything including arm.
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        if (abort) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_d = ST_WAIT_VS;
                        done_d  = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_WAIT_VS: begin
                    if (vs_fall_s) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_CAPTURE: begin
                    // An early vs edge ends the capture with a partial buffer.
                    if (wr_last_s || vs_fall_s) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
            endcase
        end
        busy_d      = (state_d == ST_WAIT_VS) || (state_d == ST_CAPTURE);
        frame_cnt_d = vs_fall_s ? (frame_cnt_q + 16'd1) : frame_cnt_q;
        vs_d        = pix_ce ? vs : vs_q;
        rd_valid_d  = rd_en;
    end

    // Controller and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vs_q        <= 1'b1;
            frame_cnt_q <= 16'd0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            vs_q        <= vs_d;
            frame_cnt_q <= frame_cnt_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

`ifdef FRAME_CAPTURE_CRC_EN
    logic [15:0] crc_q, crc_d;

    // CRC restarts on entry to capture and folds in each written word.
    always_comb begin
        crc_d = crc_q;
        if ((state_q == ST_WAIT_VS) && (state_d == ST_CAPTURE)) begin
            crc_d = CRC_INIT;
        end else if (wr_en_s) begin
            crc_d = crc16_word(crc_q, 32'(wr_data_s), CW);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;
`endif

    capture_ram #(
        .DEPTH (DEPTH),
        .DW    (CW),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data_s),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;
    assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_frame_capture_buffer.sv
// Randomised bench for frame_capture_buffer on a shrunken raster
// (24x16 total, 20x12 visible, vs low on lines 13-14), window at (3,2),
// 6x4 captured pixels, DECIM=2. Read data is checked through a scoreboard
// queue; status is checked every clock against a frame-level model.
module tb_frame_capture_buffer;

    localparam int CWID = 4;
    localparam int X0 = 3, Y0 = 2, WW = 6, WH = 4, DEC = 2;
    localparam int DEPTH = WW * WH;
    localparam int AW = $clog2(DEPTH);
    localparam int HT = 24, HV = 20, VT = 16, VV = 12, VS0 = 13, VS1 = 15;
    localparam int M_IDLE = 0, M_WAIT = 1, M_CAP = 2, M_DONE = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              pix_ce, vs, vde, arm, abort, rd_en;
    logic [9:0]        drawX, drawY;
    logic [CWID-1:0]   Red, Green, Blue;
    logic              busy, done, rd_valid;
    logic [15:0]       frame_cnt;
    logic [AW-1:0]     rd_addr;
    logic [3*CWID-1:0] rd_data;
`ifdef FRAME_CAPTURE_CRC_EN
    logic [15:0]       crc;
`endif

    frame_capture_buffer #(
        .COLOR_W (CWID), .WIN_X0 (X0), .WIN_Y0 (Y0),
        .WIN_W (WW), .WIN_H (WH), .DECIM (DEC)
    ) dut (
        .clk (clk), .reset (reset), .pix_ce (pix_ce), .vs (vs), .vde (vde),
        .drawX (drawX), .drawY (drawY), .Red (Red), .Green (Green), .Blue (Blue),
        .arm (arm), .abort (abort), .busy (busy), .done (done),
        .frame_cnt (frame_cnt), .rd_en (rd_en), .rd_addr (rd_addr),
        .rd_data (rd_data),
`ifdef FRAME_CAPTURE_CRC_EN
        .crc (crc),
`endif
        .rd_valid (rd_valid)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_mode;
    bit          m_vs_prev;
    logic [15:0] m_fcnt;
    logic [15:0] m_crc;
    logic [11:0] m_mem [DEPTH];

    int          n_cmp = 0;
    int          n_err = 0;
    logic [11:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [11:0] w);
        logic [15:0] r;
        bit b;
        r = c;
        for (int i = 11; i >= 0; i--) begin
            b = r[15] ^ w[i];
            r = r << 1;
            if (b) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    task automatic check_status();
        check("busy", 32'(busy), 32'(m_mode == M_WAIT || m_mode == M_CAP));
        check("done", 32'(done), 32'(m_mode == M_DONE));
        check("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
`ifdef FRAME_CAPTURE_CRC_EN
        if (m_mode == M_DONE) check("crc", 32'(crc), 32'(m_crc));
`endif
    endtask

    task automatic clk_step();
        @(negedge clk);
        check_status();
    endtask

    task automatic idle_cycle();
        pix_ce = 1'b0; arm = 1'b0; abort = 1'b0; rd_en = 1'b0;
        clk_step();
    endtask

    task automatic ctrl(input bit a, input bit b);
        pix_ce = 1'b0; arm = a; abort = b;
        if (b) m_mode = M_IDLE;
        else if (a && (m_mode == M_IDLE || m_mode == M_DONE)) m_mode = M_WAIT;
        clk_step();
        arm = 1'b0; abort = 1'b0;
    endtask

    task automatic pixel(input int x, input int y, input int vis);
        bit          fall, v_de, v_vs;
        logic [11:0] word;
        int          a;
        v_de = (x < HV) && (y < vis);
        v_vs = !(y >= VS0 && y < VS1);
        word = 12'($urandom);
        pix_ce = 1'b1; drawX = 10'(x); drawY = 10'(y); vde = v_de; vs = v_vs;
        {Blue, Green, Red} = word;
        fall = m_vs_prev && !v_vs;
        m_vs_prev = v_vs;
        if (fall) m_fcnt = m_fcnt + 16'd1;
        if (m_mode == M_WAIT) begin
            if (fall) begin
                m_mode = M_CAP;
                m_crc = 16'hFFFF;
            end
        end else if (m_mode == M_CAP) begin
            if (v_de && x >= X0 && x < X0 + WW * DEC && y >= Y0 && y < Y0 + WH * DEC &&
                (x - X0) % DEC == 0 && (y - Y0) % DEC == 0) begin
                a = ((y - Y0) / DEC) * WW + (x - X0) / DEC;
                m_mem[a] = word;
                m_crc = crc_model(m_crc, word);
                if (a == DEPTH - 1) m_mode = M_DONE;
            end
            if (fall) m_mode = M_DONE;
        end
        clk_step();
        pix_ce = 1'b0;
        if ($urandom_range(3) == 0) idle_cycle();
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        #1 reset = 1'b0;
        m_mode = M_IDLE; m_fcnt = 16'd0; m_vs_prev = 1'b1;
    endtask

    task automatic frame(input int vis, input int arm_at, input int abort_at, input int rst_at);
        int idx;
        for (int y = 0; y < VT; y++) begin
            for (int x = 0; x < HT; x++) begin
                idx = y * HT + x;
                if (idx == arm_at || idx == abort_at) ctrl(idx == arm_at, idx == abort_at);
                if (idx == rst_at) async_reset();
                pixel(x, y, vis);
            end
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) begin
            pix_ce = 1'b0; rd_en = 1'b1; rd_addr = AW'(a);
            exp_q.push_back(m_mem[a]);
            clk_step();
            rd_en = 1'b0;
            if ($urandom_range(1) == 1) idle_cycle();
        end
        idle_cycle();
        idle_cycle();
    endtask

    // Read-data monitor: every rd_valid must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rd_valid_unexpected at %0t: got 1 expected 0", $time);
            end else begin
                check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        reset = 1'b1; pix_ce = 1'b0; vs = 1'b1; vde = 1'b0; arm = 1'b0; abort = 1'b0;
        rd_en = 1'b0; rd_addr = '0; drawX = '0; drawY = '0;
        Red = '0; Green = '0; Blue = '0;
        m_mode = M_IDLE; m_fcnt = 16'd0; m_vs_prev = 1'b1; m_crc = 16'hFFFF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        idle_cycle();
        frame(VV, -1, -1, -1);                       // idle frame, counter only
        frame(VV, 5 * HT + 7, -1, -1);               // arm mid-frame
        frame(VV, 4 * HT + 2, -1, -1);               // full capture; arm while busy ignored
        read_all();
        frame(VV, -1, -1, -1);                       // done stays sticky
        frame(VV, 6 * HT, -1, -1);                   // re-arm clears done
        frame($urandom_range(3, 7), -1, -1, -1);     // short frame -> partial buffer
        read_all();
        frame(VV, 3 * HT + 1, -1, -1);               // arm
        frame(VV, 5 * HT + 4, 5 * HT + 4, -1);       // abort together with arm mid-capture
        frame(VV, -1, -1, -1);                       // remains idle
        frame(VV, 2 * HT, -1, -1);                   // arm
        frame(VV, -1, -1, 5 * HT + 9);               // async reset mid-capture
        frame(VV, -1, -1, -1);
        read_all();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
